fp_sub_seq: RTL and testbench

Multi-cycle IEEE-754 double-precision subtractor computing `result = a - b` behind a valid/ready handshake on both sides. It is the sequential companion to the combinational double-precision adder in the FPU datapath. It uses the same packed 64-bit operand format, the same special-value policy and truncating (round-toward-zero on magnitude) arithmetic. Normalization is iterative, one bit per cycle, to keep the block small.

---
 rtl/fp64_pkg.sv | 31 +++
 rtl/fp64_classify.sv | 26 ++
 rtl/fp_sub_seq.sv | 187 ++++++++++++++++++
 tb/tb_fp_sub_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fp64_pkg.sv
// fp64_pkg: shared definitions for the double-precision FPU blocks.
//   Field widths, special encodings, the unpacked-operand record and the
//   sequencer state enum used by fp_sub_seq.
package fp64_pkg;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  // Working mantissa: {carry, hidden, frac}
  localparam int MANT_W = FRAC_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FF;
  localparam logic [63:0]      QNAN    = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_ADDSUB = 3'd2,
    ST_NORM   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
  } fp_class_t;

endpackage

// File: rtl/fp64_classify.sv
// fp64_classify: combinational unpack and classification of a packed double.
//   i_x   : packed IEEE-754 double
//   o_cls : sign/exp/frac fields plus NaN / infinity / zero flags
module fp64_classify
  import fp64_pkg::*;
(
  input  logic [63:0] i_x,
  output fp_class_t   o_cls
);

  logic w_exp_max;
  logic w_frac_nz;

  always_comb begin
    w_exp_max     = (i_x[62:52] == EXP_MAX);
    w_frac_nz     = (i_x[51:0] != '0);
    o_cls.sign    = i_x[63];
    o_cls.exp     = i_x[62:52];
    o_cls.frac    = i_x[51:0];
    o_cls.is_nan  = w_exp_max & w_frac_nz;
    o_cls.is_inf  = w_exp_max & ~w_frac_nz;
    // Zero of either sign; subnormals are not zero
    o_cls.is_zero = (i_x[62:0] == '0);
  end

endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle double-precision subtractor, result = a - b.
//   Truncating arithmetic, iterative one-bit-per-cycle normalization.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (ready only when idle)
//   a, b                : minuend / subtrahend, packed doubles
//   out_valid/out_ready : result handshake, result held until accepted
//   result              : packed double a - b
module fp_sub_seq
  import fp64_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result
);

  state_t r_state, w_next;

  logic [63:0]       r_a, r_b;
  logic [MANT_W-1:0] r_ma, r_mb;   // aligned magnitudes
  logic [EXP_W-1:0]  r_e;          // working exponent
  logic              r_sa, r_sb;   // sign of a, effective (inverted) sign of b
  logic [MANT_W-1:0] r_m;          // add/sub result being normalized
  logic              r_sign;
  logic [63:0]       r_res;
  logic              r_out_valid;

  fp_class_t w_ca, w_cb;

  fp64_classify u_cls_a (.i_x(r_a), .o_cls(w_ca));
  fp64_classify u_cls_b (.i_x(r_b), .o_cls(w_cb));

  // ---------------- special-case detection ----------------
  logic        w_special;
  logic [63:0] w_spec_res;

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = '0;
    if (w_ca.is_nan || w_cb.is_nan)
      w_spec_res = QNAN;
    else if (w_ca.is_inf && w_cb.is_inf && (w_ca.sign == w_cb.sign))
      w_spec_res = QNAN;
    else if (w_ca.is_inf)
      w_spec_res = r_a;
    else if (w_cb.is_inf)
      w_spec_res = {~r_b[63], r_b[62:0]};
    else if (w_ca.is_zero && w_cb.is_zero)
      w_spec_res = {w_ca.sign & ~w_cb.sign, 63'b0};
    else
      w_special = 1'b0;
  end

  // ---------------- alignment ----------------
  logic [EXP_W-1:0]  w_ea, w_eb, w_diff, w_e_al;
  logic [MANT_W-1:0] w_ma, w_mb, w_src, w_shifted, w_ma_al, w_mb_al;
  logic              w_a_ge;

  always_comb begin
    // Subnormals share the exponent of the smallest normal
    w_ea      = (w_ca.exp == '0) ? 11'd1 : w_ca.exp;
    w_eb      = (w_cb.exp == '0) ? 11'd1 : w_cb.exp;
    w_ma      = {1'b0, (w_ca.exp != '0), w_ca.frac};
    w_mb      = {1'b0, (w_cb.exp != '0), w_cb.frac};
    w_a_ge    = (w_ea >= w_eb);
    w_diff    = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
    w_src     = w_a_ge ? w_mb : w_ma;
    w_shifted = (w_diff >= 11'd54) ? '0 : (w_src >> w_diff);
    w_ma_al   = w_a_ge ? w_ma : w_shifted;
    w_mb_al   = w_a_ge ? w_shifted : w_mb;
    w_e_al    = w_a_ge ? w_ea : w_eb;
  end

  // ---------------- normalization / pack ----------------
  logic              w_norm_shift;
  logic [EXP_W-1:0]  w_e_inc;
  logic [63:0]       w_pack;

  always_comb begin
    w_e_inc      = r_e + 11'd1;
    w_norm_shift = (r_m != '0) && !r_m[53] && !r_m[52] && (r_e > 11'd1);
    if (r_m == '0)
      w_pack = '0;                              // exact cancellation is +0
    else if (r_m[53])
      w_pack = (w_e_inc == EXP_MAX) ? {r_sign, EXP_MAX, 52'b0}
                                    : {r_sign, w_e_inc, r_m[52:1]};
    else
      w_pack = {r_sign, (r_m[52] ? r_e : 11'd0), r_m[51:0]};
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_next = ST_ALIGN;
      ST_ALIGN:  w_next = w_special ? ST_DONE : ST_ADDSUB;
      ST_ADDSUB: w_next = ST_NORM;
      ST_NORM:   w_next = w_norm_shift ? ST_NORM : ST_DONE;
      ST_DONE:   if (out_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = r_out_valid;
    result    = r_res;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_e         <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_m         <= '0;
      r_sign      <= 1'b0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        ST_ALIGN: begin
          if (w_special) begin
            r_res       <= w_spec_res;
            r_out_valid <= 1'b1;
          end else begin
            r_ma <= w_ma_al;
            r_mb <= w_mb_al;
            r_e  <= w_e_al;
            r_sa <= w_ca.sign;
            r_sb <= ~w_cb.sign;
          end
        end
        ST_ADDSUB: begin
          // After alignment the larger-exponent operand always has the
          // larger mantissa, so a plain compare picks the larger magnitude.
          if (r_sa == r_sb) begin
            r_m    <= r_ma + r_mb;
            r_sign <= r_sa;
          end else if (r_ma >= r_mb) begin
            r_m    <= r_ma - r_mb;
            r_sign <= r_sa;
          end else begin
            r_m    <= r_mb - r_ma;
            r_sign <= r_sb;
          end
        end
        ST_NORM: begin
          if (w_norm_shift) begin
            r_m <= r_m << 1;
            r_e <= r_e - 11'd1;
          end else begin
            r_res       <= w_pack;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: directed self-checking bench for fp_sub_seq.
//   An arithmetic reference model computes the expected result and latency;
//   a negedge compare process checks every busy cycle against it.
module tb_fp_sub_seq;
  import fp64_pkg::*;

  localparam longint H52 = 64'h0010_0000_0000_0000;
  localparam longint H53 = 64'h0020_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] a_i = '0, b_i = '0;
  logic        in_ready, out_valid;
  logic [63:0] result;

  fp_sub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          pend = 1'b0;
  bit          seen = 1'b0;
  int          acc = 0;
  logic [63:0] exp_res = '0;
  int          exp_lat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Reference: value-level a - b with truncated alignment, then count the
  // left shifts needed to bring the magnitude back to normal range.
  function automatic void model(input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output int lat);
    int xe, ye, ea, eb, e;
    logic s;
    longint ma, mb, va, vb, sum;
    logic [63:0] m;
    bit xnan, ynan, xinf, yinf, xz, yz;
    xe = int'(x[62:52]);
    ye = int'(y[62:52]);
    xnan = (xe == 2047) && (x[51:0] != 0);
    ynan = (ye == 2047) && (y[51:0] != 0);
    xinf = (xe == 2047) && (x[51:0] == 0);
    yinf = (ye == 2047) && (y[51:0] == 0);
    xz = (x[62:0] == 0);
    yz = (y[62:0] == 0);
    lat = 1;
    r = '0;
    if (xnan || ynan) r = QNAN;
    else if (xinf && yinf && x[63] == y[63]) r = QNAN;
    else if (xinf) r = x;
    else if (yinf) r = {~y[63], y[62:0]};
    else if (xz && yz) r = {x[63] & ~y[63], 63'b0};
    else begin
      ma = longint'({12'b0, x[51:0]}) + ((xe != 0) ? H52 : 64'sd0);
      mb = longint'({12'b0, y[51:0]}) + ((ye != 0) ? H52 : 64'sd0);
      ea = (xe == 0) ? 1 : xe;
      eb = (ye == 0) ? 1 : ye;
      e  = (ea > eb) ? ea : eb;
      if (ea < e) ma = (e - ea >= 54) ? 64'sd0 : (ma >> (e - ea));
      if (eb < e) mb = (e - eb >= 54) ? 64'sd0 : (mb >> (e - eb));
      va  = x[63] ? -ma : ma;
      vb  = y[63] ? mb : -mb;
      sum = va + vb;
      s   = (sum < 0);
      m   = 64'(s ? -sum : sum);
      lat = 3;
      if (m == 0) r = '0;
      else if (m >= H53) begin
        m = m >> 1;
        e++;
        r = (e == 2047) ? {s, 11'h7FF, 52'b0} : {s, 11'(e), m[51:0]};
      end else begin
        while (m < H52 && e > 1) begin
          m = m << 1;
          e--;
          lat++;
        end
        r = {s, (m >= H52) ? 11'(e) : 11'd0, m[51:0]};
      end
    end
  endfunction

  // Per-cycle compare against the model while an operation is in flight
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend) begin
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (out_valid) begin
          if (!seen) begin
            chk("latency", 64'(cyc - acc), 64'(exp_lat));
            seen = 1'b1;
          end
          chk("result", result, exp_res);
        end
      end else begin
        chk("idle_out_valid", 64'(out_valid), 64'd0);
      end
    end
  end

  task automatic start_op(input logic [63:0] x, input logic [63:0] y, input bit hold);
    @(posedge clk); #1;
    a_i = x; b_i = y; in_valid = 1'b1; out_ready = !hold;
    @(posedge clk); #1;
    acc = cyc; pend = 1'b1; seen = 1'b0; in_valid = 1'b0;
    a_i = {$urandom, $urandom};
    b_i = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input bit hold,
                        input logic [63:0] lit, input int lit_lat);
    logic [63:0] mr;
    int ml;
    int n;
    model(x, y, mr, ml);
    chk("model_res", mr, lit);
    chk("model_lat", 64'(ml), 64'(lit_lat));
    exp_res = mr;
    exp_lat = ml;
    start_op(x, y, hold);
    n = 0;
    while (!out_valid && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL timeout: no out_valid after %0d cycles, want %h", n, exp_res);
    end
    if (hold) begin
      repeat (10) begin
        @(posedge clk); #1;
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", result, exp_res);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    pend = 1'b0;
    chk("post_in_ready", 64'(in_ready), 64'd1);
    chk("post_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", result, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(64'h4008000000000000, 64'h3FF0000000000000, 1'b0, 64'h4000000000000000, 3);
    run_op(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h0000000000000000, 3);
    run_op(64'h0000000000000002, 64'h0000000000000001, 1'b0, 64'h0000000000000001, 3);
    run_op(64'h3FF0000000000000, 64'h3FEFFFFFFFFFFFFF, 1'b0, 64'h3CB0000000000000, 55);
    run_op(64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, 64'h7FF8000000000000, 1);
    run_op(64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 1);
    run_op(64'h3FF0000000000000, 64'hFFF8000000000000, 1'b0, 64'h7FF8000000000000, 1);
    run_op(64'h3FF0000000000000, 64'hFFF0000000000000, 1'b0, 64'h7FF0000000000000, 1);
    run_op(64'h7FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h7FF0000000000000, 1);
    run_op(64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 3);
    run_op(64'h8000000000000000, 64'h0000000000000000, 1'b0, 64'h8000000000000000, 1);
    run_op(64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h0000000000000000, 1);
    run_op(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'hBFF0000000000000, 4);
    run_op(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 3);
    run_op(64'h4008000000000000, 64'h3FF0000000000000, 1'b1, 64'h4000000000000000, 3);

    // Reset while iterating in NORM: operation abandoned, no output
    begin
      logic [63:0] mr;
      int ml;
      model(64'h3FF0000000000000, 64'h3FEFFFFFFFFFFFFF, mr, ml);
      exp_res = mr;
      exp_lat = ml;
      start_op(64'h3FF0000000000000, 64'h3FEFFFFFFFFFFFFF, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      pend = 1'b0;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_result", result, 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
    end
    run_op(64'h4008000000000000, 64'h3FF0000000000000, 1'b0, 64'h4000000000000000, 3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
